i2c_slave_regmap_ctrl: RTL and testbench

Controller that sequences the I2C slave datapath as a byte-addressed register map. It decodes the slave's status strobes, captures received bytes into a local register file, and feeds read data back to the slave with the `tx_data_en` handshake that releases clock stretching. It sits between `i2c_slave` and the user-side host logic, which gets a simple single-cycle register port into the same storage.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_regmap_mem.sv | 57 +++++
 rtl/i2c_slave_regmap_ctrl.sv | 173 +++++++++++++++++
 tb/tb_i2c_slave_regmap_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and status-bit indices for the I2C slave register-map controller.
// Bit indices are common with i2c_slave.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } regmap_state_t;

    localparam int ST_STA   = 0;
    localparam int ST_STO   = 1;
    localparam int ST_TXACK = 2;
    localparam int ST_RXACK = 3;
    localparam int ST_RW    = 4;

    function automatic logic [1:0] slv_mode_f(input logic en);
        return {1'b0, en};
    endfunction

endpackage

// File: rtl/i2c_regmap_mem.sv
// Byte register file: one bus write port, one host write port, registered host read.
// A bus write always wins over a host write to the same address in the same cycle.
module i2c_regmap_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          bus_we_i,
    input  logic [AW-1:0] bus_waddr_i,
    input  logic [7:0]    bus_wdata_i,
    input  logic [AW-1:0] bus_raddr_i,
    output logic [7:0]    bus_rdata_o,
    input  logic          host_en_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [7:0]    host_wdata_i,
    output logic [7:0]    host_rdata_o,
    output logic          host_wr_drop_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] host_rdata_q;
    logic       host_wr_drop_q;
    logic       host_wr;
    logic       collide;

    assign host_wr = host_en_i & host_we_i;
    assign collide = host_wr & bus_we_i & (host_addr_i == bus_waddr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            host_rdata_q   <= '0;
            host_wr_drop_q <= 1'b0;
        end else begin
            host_wr_drop_q <= collide;
            if (host_wr && !collide) begin
                mem_q[host_addr_i] <= host_wdata_i;
            end
            if (bus_we_i) begin
                mem_q[bus_waddr_i] <= bus_wdata_i;
            end
            // Reads the pre-write contents, so a same-cycle write is not visible yet.
            if (host_en_i && !host_we_i) begin
                host_rdata_q <= mem_q[host_addr_i];
            end
        end
    end

    assign bus_rdata_o    = mem_q[bus_raddr_i];
    assign host_rdata_o   = host_rdata_q;
    assign host_wr_drop_o = host_wr_drop_q;

endmodule

// File: rtl/i2c_slave_regmap_ctrl.sv
// Sequences i2c_slave as a byte-addressed register map with a host-side register port.
// Optional macro I2C_REGMAP_IRQ_EN adds irq/irq_clr (end-of-write interrupt).
//
// state | meaning
// IDLE  | no transaction, busy low
// ADDR  | after (repeated) start, waiting for pointer byte or first read request
// WDATA | master writing data bytes at ptr
// RDATA | master reading bytes from ptr
module i2c_slave_regmap_ctrl
    import i2c_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter logic [19:0] TIMEOUT  = 20'd100000,
    parameter int          AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [7:0]    slv_status,
    input  logic [7:0]    slv_data_out,
    output logic [7:0]    slv_data_in,
    output logic          slv_tx_data_en,
    output logic [1:0]    slv_mode,
    output logic [6:0]    slv_addr,
    output logic [19:0]   slv_time_out,
    input  logic          host_en,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          host_wr_drop,
    output logic          busy
`ifdef I2C_REGMAP_IRQ_EN
    ,
    input  logic          irq_clr,
    output logic          irq
`endif
);

    regmap_state_t state_q;
    logic [AW-1:0] ptr_q;
    logic [7:0]    slv_data_in_q;
    logic          tx_en_q;
    logic          busy_q;
    logic          rx_ack_q;
    logic          tx_ack_q;

    logic          sta;
    logic          sto;
    logic          rw;
    logic          rx_rise;
    logic          tx_rise;
    logic          bus_we;
    logic [7:0]    bus_rdata;
    logic          unused_ok;

    assign sta     = slv_status[ST_STA];
    assign sto     = slv_status[ST_STO];
    assign rw      = slv_status[ST_RW];
    assign rx_rise = slv_status[ST_RXACK] & ~rx_ack_q;
    assign tx_rise = slv_status[ST_TXACK] & ~tx_ack_q;

    assign bus_we = enable & ~sto & ~sta & (state_q == WDATA) & rx_rise;

    assign unused_ok = &{1'b0, slv_status[7:5], slv_data_out};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            slv_data_in_q <= '0;
            tx_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            rx_ack_q      <= 1'b0;
            tx_ack_q      <= 1'b0;
        end else begin
            rx_ack_q <= slv_status[ST_RXACK];
            tx_ack_q <= slv_status[ST_TXACK];
            tx_en_q  <= 1'b0;
            if (!enable || sto) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else if (sta) begin
                // Repeated start keeps ptr so a write-pointer / read sequence works.
                state_q <= ADDR;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (tx_rise && rw) begin
                            state_q       <= RDATA;
                            slv_data_in_q <= bus_rdata;
                            tx_en_q       <= 1'b1;
                            ptr_q         <= ptr_q + AW'(1);
                        end else if (rx_rise && !rw) begin
                            state_q <= WDATA;
                            ptr_q   <= slv_data_out[AW-1:0];
                        end
                    end
                    WDATA: begin
                        if (rx_rise) begin
                            ptr_q <= ptr_q + AW'(1);
                        end
                    end
                    RDATA: begin
                        if (tx_rise) begin
                            slv_data_in_q <= bus_rdata;
                            tx_en_q       <= 1'b1;
                            ptr_q         <= ptr_q + AW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    i2c_regmap_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus_we_i       (bus_we),
        .bus_waddr_i    (ptr_q),
        .bus_wdata_i    (slv_data_out),
        .bus_raddr_i    (ptr_q),
        .bus_rdata_o    (bus_rdata),
        .host_en_i      (host_en),
        .host_we_i      (host_we),
        .host_addr_i    (host_addr),
        .host_wdata_i   (host_wdata),
        .host_rdata_o   (host_rdata),
        .host_wr_drop_o (host_wr_drop)
    );

`ifdef I2C_REGMAP_IRQ_EN
    logic wrote_q;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrote_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (bus_we) begin
                wrote_q <= 1'b1;
            end else if (sto || !enable) begin
                wrote_q <= 1'b0;
            end
            if (sto && enable && wrote_q) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq = irq_q;
`endif

    assign slv_data_in    = slv_data_in_q;
    assign slv_tx_data_en = tx_en_q;
    assign busy           = busy_q;
    assign slv_mode       = slv_mode_f(enable);
    assign slv_addr       = DEV_ADDR;
    assign slv_time_out   = TIMEOUT;

endmodule

// File: tb/tb_i2c_slave_regmap_ctrl.sv
// Directed bench for i2c_slave_regmap_ctrl; read data checked through an expected-byte queue.
module tb_i2c_slave_regmap_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          sta, sto, txack, rxack, rw;
    logic [7:0]    slv_status;
    logic [7:0]    slv_data_out;
    logic [7:0]    slv_data_in;
    logic          slv_tx_data_en;
    logic [1:0]    slv_mode;
    logic [6:0]    slv_addr;
    logic [19:0]   slv_time_out;
    logic          host_en, host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          host_wr_drop;
    logic          busy;
`ifdef I2C_REGMAP_IRQ_EN
    logic          irq_clr;
    logic          irq;
`endif

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_txen  = 0;
    int         n0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    logic [7:0] rd;

    assign slv_status = {2'b00, rw, rxack, txack, sto, sta};

    always #5 clk = ~clk;

    i2c_slave_regmap_ctrl #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .slv_status     (slv_status),
        .slv_data_out   (slv_data_out),
        .slv_data_in    (slv_data_in),
        .slv_tx_data_en (slv_tx_data_en),
        .slv_mode       (slv_mode),
        .slv_addr       (slv_addr),
        .slv_time_out   (slv_time_out),
        .host_en        (host_en),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_wr_drop   (host_wr_drop),
        .busy           (busy)
`ifdef I2C_REGMAP_IRQ_EN
        ,
        .irq_clr        (irq_clr),
        .irq            (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (slv_tx_data_en === 1'b1) begin
            n_txen++;
            if (exp_q.size() == 0) begin
                check("tx_en_unexpected", 32'd1, 32'd0);
            end else begin
                exp_b = exp_q.pop_front();
                check("slv_data_in", {24'd0, slv_data_in}, {24'd0, exp_b});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_c();
        sta = 1'b1; tick(); sta = 1'b0;
    endtask

    task automatic stop_c();
        sto = 1'b1; tick(); sto = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] b);
        slv_data_out = b; rxack = 1'b1; tick(); rxack = 1'b0; tick();
    endtask

    task automatic rbyte(input logic [7:0] expb);
        exp_q.push_back(expb);
        txack = 1'b1; tick(); txack = 1'b0; tick();
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_en = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [7:0] d);
        host_en = 1'b1; host_we = 1'b0; host_addr = a;
        tick();
        host_en = 1'b0;
        d = host_rdata;
    endtask

    // Bus data byte with a host access driven in the same cycle.
    task automatic bus_with_host(input logic [7:0] b, input logic hwe,
                                 input logic [AW-1:0] ha, input logic [7:0] hd);
        slv_data_out = b; rxack = 1'b1;
        host_en = 1'b1; host_we = hwe; host_addr = ha; host_wdata = hd;
        tick();
        rxack = 1'b0; host_en = 1'b0; host_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        sta = 0; sto = 0; txack = 0; rxack = 0; rw = 0;
        slv_data_out = 0; host_en = 0; host_we = 0; host_addr = 0; host_wdata = 0;
`ifdef I2C_REGMAP_IRQ_EN
        irq_clr = 0;
`endif
        repeat (3) tick();
        check("rst_data_in", {24'd0, slv_data_in}, 32'd0);
        check("rst_tx_en", {31'd0, slv_tx_data_en}, 32'd0);
        check("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
        check("rst_wr_drop", {31'd0, host_wr_drop}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("slv_mode_en", {30'd0, slv_mode}, 32'd1);
        check("slv_addr", {25'd0, slv_addr}, 32'h50);
        check("slv_time_out", {12'd0, slv_time_out}, 32'd100000);
        rst = 1'b0;
        tick();

        // Master write: pointer 3, data AA BB
        host_write(4'd5, 8'h55);
        start_c();
        check("busy_after_sta", {31'd0, busy}, 32'd1);
        rw = 1'b0;
        wbyte(8'h03); wbyte(8'hAA); wbyte(8'hBB);
        check("busy_before_sto", {31'd0, busy}, 32'd1);
        stop_c();
        check("busy_after_sto", {31'd0, busy}, 32'd0);
        host_read(4'd3, rd); check("mem3", {24'd0, rd}, 32'hAA);
        host_read(4'd4, rd); check("mem4", {24'd0, rd}, 32'hBB);
        // ptr now 5: a read starts there
        start_c(); rw = 1'b1; rbyte(8'h55); stop_c(); tick();

        // Pointer write, repeated start, three reads
        host_write(4'd2, 8'h11); host_write(4'd3, 8'h22); host_write(4'd4, 8'h33);
        start_c(); rw = 1'b0; wbyte(8'h02);
        rw = 1'b1; start_c();
        n0 = n_txen;
        rbyte(8'h11); rbyte(8'h22); rbyte(8'h33);
        stop_c(); tick();
        check("tx_en_count3", n_txen - n0, 32'd3);

        // Wrap and pointer truncation
        start_c(); rw = 1'b0; wbyte(8'h0F); wbyte(8'h5A); wbyte(8'h5B); stop_c();
        host_read(4'd15, rd); check("wrap_mem15", {24'd0, rd}, 32'h5A);
        host_read(4'd0, rd);  check("wrap_mem0", {24'd0, rd}, 32'h5B);
        start_c(); wbyte(8'h13); wbyte(8'h77); stop_c();
        host_read(4'd3, rd); check("ptr_trunc_mem3", {24'd0, rd}, 32'h77);

`ifdef I2C_REGMAP_IRQ_EN
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check("irq_cleared", {31'd0, irq}, 32'd0);
        start_c(); rw = 1'b0; wbyte(8'h0C); wbyte(8'h01); stop_c();
        check("irq_after_write", {31'd0, irq}, 32'd1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check("irq_clr", {31'd0, irq}, 32'd0);
        start_c(); rw = 1'b1; rbyte(8'h00); stop_c(); tick();
        check("irq_read_only", {31'd0, irq}, 32'd0);
`endif

        // Collisions and same-cycle host accesses
        start_c(); rw = 1'b0; wbyte(8'h06);
        bus_with_host(8'hC3, 1'b1, 4'd6, 8'h3C);
        check("drop_pulse", {31'd0, host_wr_drop}, 32'd1);
        tick();
        check("drop_cleared", {31'd0, host_wr_drop}, 32'd0);
        bus_with_host(8'hD4, 1'b1, 4'd9, 8'h99);
        check("no_drop_diff_addr", {31'd0, host_wr_drop}, 32'd0);
        tick();
        bus_with_host(8'hE5, 1'b0, 4'd8, 8'h00);
        check("read_old_value", {24'd0, host_rdata}, 32'h00);
        tick();
        stop_c();
        host_read(4'd6, rd); check("collide_mem6", {24'd0, rd}, 32'hC3);
        host_read(4'd7, rd); check("mem7", {24'd0, rd}, 32'hD4);
        host_read(4'd9, rd); check("host_mem9", {24'd0, rd}, 32'h99);
        host_read(4'd8, rd); check("mem8", {24'd0, rd}, 32'hE5);

        // Disabled: FSM held idle, bus writes blocked
        enable = 1'b0;
        tick();
        check("slv_mode_dis", {30'd0, slv_mode}, 32'd0);
        start_c(); rw = 1'b0; wbyte(8'h0A); wbyte(8'hEE);
        check("busy_disabled", {31'd0, busy}, 32'd0);
        stop_c();
        enable = 1'b1;
        host_read(4'd10, rd); check("mem10_blocked", {24'd0, rd}, 32'h00);

        // sta and sto together: stop wins
        sta = 1'b1; sto = 1'b1; tick(); sta = 1'b0; sto = 1'b0;
        check("sto_priority", {31'd0, busy}, 32'd0);

        // Reset between read bytes
        host_write(4'd1, 8'h42); host_write(4'd2, 8'h43);
        start_c(); rw = 1'b0; wbyte(8'h01);
        rw = 1'b1; start_c(); rbyte(8'h42);
        rst = 1'b1; tick(); rst = 1'b0;
        n0 = n_txen;
        txack = 1'b1; tick(); txack = 1'b0; tick(); tick();
        check("no_tx_after_rst", n_txen - n0, 32'd0);
        check("rst2_data_in", {24'd0, slv_data_in}, 32'd0);
        check("rst2_tx_en", {31'd0, slv_tx_data_en}, 32'd0);
        check("rst2_host_rdata", {24'd0, host_rdata}, 32'd0);
        check("rst2_wr_drop", {31'd0, host_wr_drop}, 32'd0);
        check("rst2_busy", {31'd0, busy}, 32'd0);
        host_read(4'd1, rd); check("rst2_mem_cleared", {24'd0, rd}, 32'd0);
        check("exp_queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
